// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, a read-valid strobe and sticky overflow/underflow error flags.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [WIDTH-1:0]           write_data,
  input  logic                       read,
  output logic [WIDTH-1:0]           read_data,
  output logic                       read_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  // A read at full frees its slot in the same cycle, so the write may proceed.
  assign rd_ok = read && !empty;
  assign wr_ok = write && (!full || rd_ok);

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // Storage: not reset; writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      read_valid <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        read_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (write && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (read && !rd_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based
// reference model of the FIFO's occupancy, data order and error flags.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int VEC_W = 1 + WIDTH + CNT_W + 6;

  logic             clk;
  logic             reset;
  logic             write;
  logic [WIDTH-1:0] write_data;
  logic             read;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_rvalid;
  logic             m_ovf;
  logic             m_udf;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .write_data(write_data),
    .read(read), .read_data(read_data), .read_valid(read_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VEC_W-1:0] exp_vec();
    int n = q.size();
    return {m_rvalid, m_rdata, CNT_W'(n), n == DEPTH, n == 0, n >= AF, n <= AE,
            m_ovf, m_udf};
  endfunction

  function automatic logic [VEC_W-1:0] obs_vec();
    return {read_valid, read_data, count, full, empty, almost_full, almost_empty,
            overflow, underflow};
  endfunction

  // Apply one cycle of stimulus and advance the model by the FIFO's rules.
  task automatic step(input logic w, input logic [WIDTH-1:0] wd, input logic r);
    logic rd_ok, wr_ok;
    write = w; write_data = wd; read = r;
    @(posedge clk);
    rd_ok = r && (q.size() != 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    if (rd_ok) m_rdata = q.pop_front();
    m_rvalid = rd_ok;
    if (wr_ok) q.push_back(wd);
    if (w && !wr_ok) m_ovf = 1'b1;
    if (r && !rd_ok) m_udf = 1'b1;
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic r);
    reset = 1'b1; write = w; write_data = 8'h5A; read = r;
    @(posedge clk);
    q.delete();
    m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    reset = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state obs=%h exp=%h", obs_vec(), exp_vec());
    end
    checks++;
    if ({count, empty, almost_empty, full, read_valid, read_data, overflow, underflow}
        !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_consts count=%0d empty=%b ae=%b full=%b rv=%b rd=%h ovf=%b udf=%b",
               count, empty, almost_empty, full, read_valid, read_data, overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, WIDTH'(i), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL fill_%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (almost_full !== (i >= 14)) begin
        failures++;
        $display("FAIL fill_af_%0d almost_full=%b want=%b", i, almost_full, i >= 14);
      end
    end
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL full_after_16 full=%b want=1", full);
    end
    step(1'b1, 8'hAA, 1'b0);
    checks++;
    if ({count, overflow} !== {5'd16, 1'b1}) begin
      failures++;
      $display("FAIL overflow_17th count=%0d ovf=%b want 16/1", count, overflow);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      checks++;
      if ({read_valid, read_data} !== {1'b1, WIDTH'(i)}) begin
        failures++;
        $display("FAIL drain_%0d rv=%b rd=%h want 1/%h", i, read_valid, read_data, WIDTH'(i));
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL drain_model_%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_after_drain empty=%b want=1", empty);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, WIDTH'($urandom), 1'b1);
      checks++;
      if (obs_vec() !== exp_vec() || count !== 5'd3) begin
        failures++;
        $display("FAIL wrap_%0d obs=%h exp=%h count=%0d", i, obs_vec(), exp_vec(), count);
      end
    end
  endtask

  task automatic test_simul();
    logic [WIDTH-1:0] extra;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'($urandom), 1'b0);
    extra = 8'hC3;
    step(1'b1, extra, 1'b1);
    checks++;
    if ({count, overflow, read_valid} !== {5'd16, 1'b0, 1'b1} || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL rw_at_full count=%0d ovf=%b rv=%b obs=%h exp=%h",
               count, overflow, read_valid, obs_vec(), exp_vec());
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    checks++;
    if (read_data !== extra) begin
      failures++;
      $display("FAIL rw_full_stored rd=%h want=%h", read_data, extra);
    end
    step(1'b1, 8'h3C, 1'b1);
    checks++;
    if ({count, underflow, read_valid} !== {5'd1, 1'b1, 1'b0} || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL rw_at_empty count=%0d udf=%b rv=%b want 1/1/0", count, underflow, read_valid);
    end
  endtask

  task automatic test_underflow();
    logic [WIDTH-1:0] held;
    do_reset(1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, '0, 1'b1);
    held = read_data;
    step(1'b0, '0, 1'b1);
    checks++;
    if ({underflow, read_valid, read_data} !== {1'b1, 1'b0, 8'h77} || held !== 8'h77) begin
      failures++;
      $display("FAIL underflow udf=%b rv=%b rd=%h held=%h want 1/0/77",
               underflow, read_valid, read_data, held);
    end
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
    checks++;
    if (underflow !== 1'b1 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL underflow_sticky udf=%b obs=%h exp=%h", underflow, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0);
    do_reset(1'b1, 1'b0);
    checks++;
    if ({count, empty, overflow} !== {5'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid count=%0d empty=%b ovf=%b want 0/1/0", count, empty, overflow);
    end
    step(1'b1, 8'h91, 1'b0);
    step(1'b1, 8'h92, 1'b0);
    step(1'b0, '0, 1'b1);
    checks++;
    if ({read_valid, read_data} !== {1'b1, 8'h91}) begin
      failures++;
      $display("FAIL reset_refill rv=%b rd=%h want 1/91", read_valid, read_data);
    end
  endtask

  task automatic test_random();
    logic w, r;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      // Shift the write/read bias every 250 cycles to reach both boundaries.
      if ((i / 250) % 2 == 0) begin
        w = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 4);
      end else begin
        w = ($urandom_range(0, 9) < 4); r = ($urandom_range(0, 9) < 7);
      end
      step(w, WIDTH'($urandom), r);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; read = 1'b0; write_data = '0;
    m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next-generation general-purpose buffer for the datapath, generalised in data width and depth. It adds full/empty and programmable almost-full/almost-empty flags, an occupancy count, a read-valid strobe, and sticky overflow/underflow error flags. It sits between any producer/consumer pair sharing one clock domain.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- write  in  1  write request
- write_data  in  WIDTH  data to store
- read  in  1  read request
- read_data  out  WIDTH  registered read data
- read_valid  out  1  high one cycle after an accepted read
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: DEPTH×WIDTH array. Write and read pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. The array is not reset.
- Read accepted (rd_ok) = read && !empty.
- Write accepted (wr_ok) = write && (!full || rd_ok). When full, a simultaneous accepted read frees the slot in the same cycle.
- When empty, read && write: the read is rejected (underflow set) and the write is accepted. There is no fall-through.
- On wr_ok: mem[wr_ptr] ← write_data, wr_ptr+1.
- On rd_ok: read_data ← mem[rd_ptr], rd_ptr+1, read_valid ← 1. Otherwise read_valid ← 0 and read_data holds its last value.
- Count update: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither. Count never exceeds DEPTH or goes below 0.
- All flags are decoded from the registered count, so they reflect state after the last clock edge.
- overflow ← 1 on write && !wr_ok. underflow ← 1 on read && !rd_ok. Both are cleared only by reset.
- Reset (takes priority over everything, including mid-burst):
  - pointers = 0, count = 0
  - read_data = 0, read_valid = 0
  - full = 0, empty = 1, almost_full = 0, almost_empty = 1
  - overflow = 0, underflow = 0
  - Any read or write in the reset cycle is ignored and not flagged.

## Timing
- Write-to-read latency: a word written at edge N is readable (empty = 0) from edge N. A read issued in the next cycle captures it at edge N+1.
- Read latency: 1 cycle. read_data and read_valid update at the edge that accepts the read.
- Flags and count change at the same edge as the accepted operation.
- Full throughput: one write and one read per cycle, sustained indefinitely at any non-boundary occupancy.

## Test plan
- Reset then idle: count = 0, empty = 1, almost_empty = 1, full = 0, read_data = 0, read_valid = 0, error flags 0.
- Write 0x01..0x10 (16 words): full = 1 after the 16th edge, almost_full = 1 from count = 14. A 17th write leaves count = 16 and sets overflow = 1. Then read 16 words: read_data = 0x01..0x10 in order with read_valid pulsing each cycle, empty = 1 at the end.
- Pointer wrap: do 40 cycles of write-then-read with an offset of 3 words. Data order is preserved across pointer wrap and count stays at 3.
- Simultaneous read+write at full: count stays 16, write_data is stored, overflow stays 0. Simultaneous read+write at empty: count → 1, underflow = 1, read_valid = 0.
- Read from empty: read = 1 at count = 0 gives underflow = 1, read_data unchanged, read_valid = 0. The flag persists until reset.
- Reset mid-operation: after 9 writes, assert reset together with write = 1. Next cycle count = 0, empty = 1, overflow = 0. The first read after refill returns the first post-reset word.
